// File: rtl/bcd_two_digit_counter_pkg.sv
// Shared constants for the two-digit BCD counter and its 7-segment display path.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package bcd_two_digit_counter_pkg;

  localparam logic [3:0] BCD_MAX = 4'd9;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;

  localparam logic [1:0] AN_ONES = 2'b10;
  localparam logic [1:0] AN_TENS = 2'b01;

  // A loaded nibble outside 0..9 becomes 0 so the digits can never hold an invalid code.
  function automatic logic [3:0] bcd_sanitize(input logic [3:0] digit);
    return (digit > BCD_MAX) ? 4'd0 : digit;
  endfunction

endpackage

// File: rtl/bcd_two_digit_counter_seg7.sv
// Combinational BCD to active-low 7-segment decoder; codes above 9 blank the digit.
module bcd_to_seg7
  import bcd_two_digit_counter_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (digit_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bcd_two_digit_counter.sv
// Two-digit BCD up/down counter stepped by rising edges of tick_in, with load,
// wrap carry and a time-multiplexed active-low two-digit display.
module bcd_two_digit_counter
  import bcd_two_digit_counter_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int SCAN_W   = 16
) (
  input  logic       clkin,
  input  logic       clr,
  input  logic       tick_in,
  input  logic       en,
  input  logic       up,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       carry,
  output logic [6:0] seg,
  output logic [1:0] an
);

  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

  logic              tick_dly_q;
  logic              step;
  logic [3:0]        tens_q, tens_d;
  logic [3:0]        ones_q, ones_d;
  logic              carry_q, carry_d;
  logic [SCAN_W-1:0] scan_q, scan_d;
  logic              sel_q, sel_d;
  logic [6:0]        seg_q;
  logic [1:0]        an_q;
  logic [3:0]        disp_digit;
  logic [6:0]        disp_seg;

  assign step = tick_in & ~tick_dly_q;

  always_comb begin
    tens_d  = tens_q;
    ones_d  = ones_q;
    carry_d = 1'b0;
    if (load) begin
      tens_d = bcd_sanitize(load_val[7:4]);
      ones_d = bcd_sanitize(load_val[3:0]);
    end else if (step && en) begin
      if (up) begin
        if (ones_q < BCD_MAX) begin
          ones_d = ones_q + 4'd1;
        end else begin
          ones_d = 4'd0;
          if (tens_q < BCD_MAX) begin
            tens_d = tens_q + 4'd1;
          end else begin
            tens_d  = 4'd0;
            carry_d = 1'b1;
          end
        end
      end else begin
        if (ones_q != 4'd0) begin
          ones_d = ones_q - 4'd1;
        end else begin
          ones_d = BCD_MAX;
          if (tens_q != 4'd0) begin
            tens_d = tens_q - 4'd1;
          end else begin
            tens_d  = BCD_MAX;
            carry_d = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    scan_d = scan_q + SCAN_W'(1);
    sel_d  = sel_q;
    if (scan_q == SCAN_LAST) begin
      scan_d = '0;
      sel_d  = ~sel_q;
    end
  end

  // Decode from next-state digit/select so the registered an and seg always agree.
  assign disp_digit = sel_d ? tens_d : ones_d;

  bcd_to_seg7 u_seg7 (
    .digit_i (disp_digit),
    .seg_o   (disp_seg)
  );

  always_ff @(posedge clkin) begin
    if (clr) begin
      tick_dly_q <= 1'b0;
      tens_q     <= 4'd0;
      ones_q     <= 4'd0;
      carry_q    <= 1'b0;
      scan_q     <= '0;
      sel_q      <= 1'b0;
      seg_q      <= SEG_0;
      an_q       <= AN_ONES;
    end else begin
      tick_dly_q <= tick_in;
      tens_q     <= tens_d;
      ones_q     <= ones_d;
      carry_q    <= carry_d;
      scan_q     <= scan_d;
      sel_q      <= sel_d;
      seg_q      <= disp_seg;
      an_q       <= sel_d ? AN_TENS : AN_ONES;
    end
  end

  assign tens  = tens_q;
  assign ones  = ones_q;
  assign carry = carry_q;
  assign seg   = seg_q;
  assign an    = an_q;

endmodule

// File: tb/tb_bcd_two_digit_counter.sv
// Self-checking bench for bcd_two_digit_counter against an integer (0..99) reference model.
module tb_bcd_two_digit_counter;

  logic       clkin = 1'b0;
  logic       clr = 1'b0;
  logic       tickIn = 1'b0;
  logic       en = 1'b0;
  logic       up = 1'b0;
  logic       load = 1'b0;
  logic [7:0] loadVal = 8'h00;
  logic [3:0] tens, ones;
  logic       carry;
  logic [6:0] seg;
  logic [1:0] an;

  int checks = 0;
  int errors = 0;

  int mCount = 0;
  int mPrevTick = 0;
  int mCarry = 0;
  int mScan = 0;
  int mSel = 0;

  localparam int SCAN_DIV = 4;

  logic [6:0] segExp [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                              7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  bcd_two_digit_counter #(.SCAN_DIV(SCAN_DIV), .SCAN_W(16)) dut (
    .clkin    (clkin),
    .clr      (clr),
    .tick_in  (tickIn),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_val (loadVal),
    .tens     (tens),
    .ones     (ones),
    .carry    (carry),
    .seg      (seg),
    .an       (an)
  );

  always #5 clkin = ~clkin;

  // One clock: the reference model applies the counter's rules to the inputs seen at the edge.
  task automatic cycle();
    int hi, lo;
    bit stepEv;
    @(posedge clkin);
    if (clr) begin
      mCount = 0; mCarry = 0; mPrevTick = 0; mScan = 0; mSel = 0;
    end else begin
      stepEv = (tickIn == 1'b1) && (mPrevTick == 0);
      mPrevTick = int'(tickIn);
      mCarry = 0;
      if (load) begin
        hi = int'(loadVal[7:4]);
        lo = int'(loadVal[3:0]);
        mCount = (hi > 9 ? 0 : hi) * 10 + (lo > 9 ? 0 : lo);
      end else if (stepEv && en) begin
        if (up) begin
          mCarry = (mCount == 99) ? 1 : 0;
          mCount = (mCount + 1) % 100;
        end else begin
          mCarry = (mCount == 0) ? 1 : 0;
          mCount = (mCount + 99) % 100;
        end
      end
      if (mScan == SCAN_DIV - 1) begin
        mScan = 0;
        mSel = 1 - mSel;
      end else begin
        mScan = mScan + 1;
      end
    end
    #1;
  endtask

  task automatic drive_cycle(input logic t);
    tickIn = t;
    cycle();
  endtask

  task automatic test_reset();
    clr = 1'b1; en = 1'b0; up = 1'b0; load = 1'b0; tickIn = 1'b0;
    cycle();
    cycle();
    checks++; if (tens !== 4'd0) begin errors++; $display("FAIL reset_tens got %0d want 0", tens); end
    checks++; if (ones !== 4'd0) begin errors++; $display("FAIL reset_ones got %0d want 0", ones); end
    checks++; if (carry !== 1'b0) begin errors++; $display("FAIL reset_carry got %b want 0", carry); end
    checks++; if (an !== 2'b10) begin errors++; $display("FAIL reset_an got %b want 10", an); end
    checks++; if (seg !== 7'b1000000) begin errors++; $display("FAIL reset_seg got %b want 1000000", seg); end
    clr = 1'b0;
  endtask

  task automatic test_count_up();
    up = 1'b1; en = 1'b1; load = 1'b0;
    for (int p = 0; p < 10; p++) begin
      for (int k = 0; k < 5; k++) begin
        drive_cycle(k < 3);
        checks++;
        if (int'(tens) * 10 + int'(ones) !== mCount || carry !== mCarry[0]) begin
          errors++;
          $display("FAIL count_up got %0d%0d c=%b want %0d c=%0d", tens, ones, carry, mCount, mCarry);
        end
      end
    end
    checks++;
    if (tens !== 4'd1 || ones !== 4'd0) begin
      errors++; $display("FAIL count_up_total got %0d%0d want 10", tens, ones);
    end
  endtask

  task automatic test_wrap_up();
    int carryCycles = 0;
    up = 1'b1; en = 1'b1; tickIn = 1'b0;
    load = 1'b1; loadVal = 8'h98;
    cycle();
    load = 1'b0;
    checks++;
    if (tens !== 4'd9 || ones !== 4'd8) begin
      errors++; $display("FAIL load_98 got %0d%0d want 98", tens, ones);
    end
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < 5; k++) begin
        drive_cycle(k < 2);
        if (carry === 1'b1) carryCycles++;
        checks++;
        if (int'(tens) * 10 + int'(ones) !== mCount || carry !== mCarry[0]) begin
          errors++;
          $display("FAIL wrap_up got %0d%0d c=%b want %0d c=%0d", tens, ones, carry, mCount, mCarry);
        end
      end
    end
    checks++; if (carryCycles != 1) begin errors++; $display("FAIL wrap_up_carry_len got %0d want 1", carryCycles); end
    checks++; if (tens !== 4'd0 || ones !== 4'd0) begin errors++; $display("FAIL wrap_up_final got %0d%0d want 00", tens, ones); end
  endtask

  task automatic test_wrap_down();
    int carryCycles = 0;
    up = 1'b0; en = 1'b1; tickIn = 1'b0;
    load = 1'b1; loadVal = 8'h00;
    cycle();
    load = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive_cycle(k < 3);
      if (carry === 1'b1) carryCycles++;
      checks++;
      if (int'(tens) * 10 + int'(ones) !== mCount || carry !== mCarry[0]) begin
        errors++;
        $display("FAIL wrap_down got %0d%0d c=%b want %0d c=%0d", tens, ones, carry, mCount, mCarry);
      end
    end
    checks++; if (carryCycles != 1) begin errors++; $display("FAIL wrap_down_carry_len got %0d want 1", carryCycles); end
    checks++; if (tens !== 4'd9 || ones !== 4'd9) begin errors++; $display("FAIL wrap_down_final got %0d%0d want 99", tens, ones); end
    load = 1'b1; loadVal = 8'hAF;
    cycle();
    checks++; if (tens !== 4'd0 || ones !== 4'd0) begin errors++; $display("FAIL load_af got %0d%0d want 00", tens, ones); end
    for (int i = 0; i < 8; i++) begin
      loadVal = 8'($urandom);
      cycle();
      checks++;
      if (int'(tens) * 10 + int'(ones) !== mCount || carry !== 1'b0) begin
        errors++;
        $display("FAIL load_rand val=%h got %0d%0d c=%b want %0d", loadVal, tens, ones, carry, mCount);
      end
    end
    load = 1'b0;
  endtask

  task automatic test_load_priority();
    up = 1'b1; en = 1'b1;
    drive_cycle(1'b0);
    load = 1'b1; loadVal = 8'h42; tickIn = 1'b1;
    cycle();
    load = 1'b0;
    checks++; if (tens !== 4'd4 || ones !== 4'd2) begin errors++; $display("FAIL load_over_step got %0d%0d want 42", tens, ones); end
    drive_cycle(1'b1);
    drive_cycle(1'b0);
    checks++; if (tens !== 4'd4 || ones !== 4'd2) begin errors++; $display("FAIL held_high_no_step got %0d%0d want 42", tens, ones); end
    en = 1'b0;
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < 4; k++) begin
        drive_cycle(k < 2);
        checks++;
        if (tens !== 4'd4 || ones !== 4'd2 || carry !== 1'b0) begin
          errors++; $display("FAIL en_low_hold got %0d%0d c=%b want 42 c=0", tens, ones, carry);
        end
      end
    end
  endtask

  task automatic test_scan();
    int guard = 0;
    logic [6:0] segWant;
    en = 1'b0; load = 1'b0; tickIn = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      segWant = (mSel == 1) ? segExp[mCount / 10] : segExp[mCount % 10];
      checks++;
      if (an !== ((mSel == 1) ? 2'b01 : 2'b10) || seg !== segWant) begin
        errors++; $display("FAIL scan an=%b seg=%b want sel=%0d seg=%b", an, seg, mSel, segWant);
      end
    end
    while (!(mSel == 1 && mScan == 2) && guard < 20) begin
      cycle();
      guard++;
    end
    checks++; if (guard >= 20) begin errors++; $display("FAIL scan_reach_tens got timeout want sel=1"); end
    checks++; if (an !== 2'b01) begin errors++; $display("FAIL scan_tens_slot an=%b want 01", an); end
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    checks++;
    if (an !== 2'b10 || seg !== 7'b1000000 || tens !== 4'd0 || ones !== 4'd0) begin
      errors++; $display("FAIL clr_mid_scan an=%b seg=%b %0d%0d want 10 1000000 00", an, seg, tens, ones);
    end
  endtask

  task automatic test_random();
    logic [6:0] segWant;
    for (int i = 0; i < 400; i++) begin
      clr = ($urandom_range(0, 49) == 0);
      load = ($urandom_range(0, 9) == 0);
      loadVal = 8'($urandom);
      en = ($urandom_range(0, 3) != 0);
      up = 1'($urandom);
      tickIn = 1'($urandom);
      cycle();
      segWant = (mSel == 1) ? segExp[mCount / 10] : segExp[mCount % 10];
      checks++;
      if (int'(tens) * 10 + int'(ones) !== mCount || carry !== mCarry[0] || tens > 4'd9 || ones > 4'd9) begin
        errors++;
        $display("FAIL random_count got %0d%0d c=%b want %0d c=%0d", tens, ones, carry, mCount, mCarry);
      end
      checks++;
      if (an !== ((mSel == 1) ? 2'b01 : 2'b10) || seg !== segWant) begin
        errors++; $display("FAIL random_display an=%b seg=%b want sel=%0d seg=%b", an, seg, mSel, segWant);
      end
    end
    clr = 1'b0; load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_wrap_up();
    test_wrap_down();
    test_load_priority();
    test_scan();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
